// File: rtl/seq_pkg.sv
// Shared definitions for the step-sequencer audio path: FSM encoding and the
// default pattern geometry also used by the audio generators and display.
package seq_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  localparam int DEF_STEPS  = 16;
  localparam int DEF_LOOP_W = 7;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for one asynchronous input, followed by a history
// flop so rising and falling edges appear as single-cycle pulses.
module edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // History resets to the same level as the chain, so reset never creates an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign rise = r_sync[STAGES-1] & ~r_hist;
  assign fall = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/loop_sequencer.sv
// Loop/step sequencer: tracks step and loop position within a pattern, plays
// for a latched number of loops (0 = forever) and flags wraps and completion.
module loop_sequencer
  import seq_pkg::*;
#(
  parameter  int STEPS       = DEF_STEPS,
  parameter  int LOOP_W      = DEF_LOOP_W,
  parameter  int SYNC_STAGES = 2,
  localparam int STEP_W      = $clog2(STEPS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              nStart,
  input  logic              nStop,
  input  logic              Step,
  input  logic [LOOP_W-1:0] Loops,
  output logic              Play,
  output logic [STEP_W-1:0] StepIdx,
  output logic [LOOP_W-1:0] LoopIdx,
  output logic              LoopWrap,
  output logic              Done
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  logic w_start, w_stop, w_step;
  logic w_start_rise, w_stop_rise, w_step_fall;

  edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_start (
    .i_clk(Clock), .i_rst(Reset), .i_async(nStart), .rise(w_start_rise), .fall(w_start)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_stop (
    .i_clk(Clock), .i_rst(Reset), .i_async(nStop), .rise(w_stop_rise), .fall(w_stop)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_step (
    .i_clk(Clock), .i_rst(Reset), .i_async(Step), .rise(w_step), .fall(w_step_fall)
  );

  logic [0:0]        r_state;
  logic [LOOP_W-1:0] r_loops_q;
  logic [STEP_W-1:0] r_step;
  logic [LOOP_W-1:0] r_loop;
  logic              r_wrap;
  logic              r_done;

  logic w_last_loop;
  assign w_last_loop = (r_loops_q != '0) && (r_loop == r_loops_q - LOOP_W'(1));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain updates within one cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_loops_q <= '0;
      r_step    <= '0;
      r_loop    <= '0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      // A stop edge masks a simultaneous start even when already idle.
      if (w_stop) begin
        r_state <= ST_IDLE;
      end else if (w_start) begin
        r_state   <= ST_PLAY;
        r_loops_q <= Loops;
        r_step    <= '0;
        r_loop    <= '0;
      end else if (w_step && r_state == ST_PLAY) begin
        if (r_step == STEP_LAST) begin
          r_step <= '0;
          r_wrap <= 1'b1;
          if (w_last_loop) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
            r_loop  <= '0;
          end else begin
            r_loop <= r_loop + LOOP_W'(1);
          end
        end else begin
          r_step <= r_step + STEP_W'(1);
        end
      end
    end
  end

  assign Play     = (r_state == ST_PLAY);
  assign StepIdx  = r_step;
  assign LoopIdx  = r_loop;
  assign LoopWrap = r_wrap;
  assign Done     = r_done;

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Parametrised loop/step sequencer for the step-sequencer audio path. It synchronises the asynchronous start, stop and step-tick inputs and tracks the current step within a pattern of `STEPS` steps. It counts completed loops and plays for `Loops` loops, or forever when `Loops` is 0. It drives `Play` plus step and loop indices to the audio generators and display, and flags loop wraps and natural completion.

## Interface
Parameters:
- `STEPS`, 16: steps per loop, ≥2; `STEP_W` = clog2(`STEPS`) derived localparam
- `LOOP_W`, 7: width of loop count and loop index
- `SYNC_STAGES`, 2: synchroniser depth for async inputs, ≥2

Ports:
- `Clock`  in  1  system clock
- `Reset`  in  1  reset: one clock; reset is synchronous and active-high
- `nStart`  in  1  async, active-low; falling edge starts or restarts playback
- `nStop`  in  1  async, active-low; falling edge aborts playback
- `Step`  in  1  async step tick; rising edge advances one step
- `Loops`  in  `LOOP_W`  loop count, sampled on start; 0 = infinite
- `Play`  out  1  high while playing
- `StepIdx`  out  `STEP_W`  current step, 0..`STEPS`-1
- `LoopIdx`  out  `LOOP_W`  current loop, 0-based
- `LoopWrap`  out  1  one-cycle pulse when `StepIdx` wraps from `STEPS`-1 to 0
- `Done`  out  1  one-cycle pulse on natural completion only

## Operation
- Each async input feeds a `SYNC_STAGES`-flop synchroniser and then a history flop. Edge = last-stage value vs history flop.
- Synchroniser reset values: `nStart`/`nStop` chains = 1; `Step` chain = 0. No spurious edge after reset.
- FSM has two states, IDLE and PLAY. Priority each cycle: `Reset` > stop edge > start edge > step edge.
- Start edge, any state: latch `Loops` into `loops_q`; `StepIdx`=0, `LoopIdx`=0; `Play`=1; go to PLAY. A start edge in PLAY is a restart. It does not pulse `Done`.
- Stop edge in PLAY: `Play`=0, go to IDLE, indices hold, no `Done`. A stop edge in IDLE is ignored.
- Step edge in PLAY with `StepIdx`<`STEPS`-1: `StepIdx`+1.
- Step edge in PLAY with `StepIdx`=`STEPS`-1: `StepIdx`=0 and `LoopWrap`=1. Then:
  - if `loops_q`≠0 and `LoopIdx`=`loops_q`-1: `Done`=1, `Play`=0, `LoopIdx`=0, go to IDLE
  - otherwise `LoopIdx`+1, wrapping modulo 2^`LOOP_W` (relevant in infinite mode only)
- Step edges in IDLE are ignored.
- Total step edges from start to `Done` = `loops_q`×`STEPS`. Counter widths are never wider than `STEP_W`/`LOOP_W`.
- A change on `Loops` during PLAY has no effect until the next start edge.

## Timing
- Reset values: `Play`=0, `StepIdx`=0, `LoopIdx`=0, `LoopWrap`=0, `Done`=0, `loops_q`=0, state IDLE.
- `Reset` asserted mid-playback clears everything on the next clock edge. Playback does not resume after deassertion.
- Input latency: an input edge that meets setup before clock edge 1 is detected combinationally after edge `SYNC_STAGES`. Outputs update at edge `SYNC_STAGES`+1, which is 3 clocks by default. Start, stop and step all have this same latency.
- All outputs are registered. `LoopWrap` and `Done` are high for exactly one clock. `Done` coincides with the final `LoopWrap` and with the falling edge of `Play`.
- Minimum input pulse width is `SYNC_STAGES`+1 clocks high and low. Shorter pulses may be missed.

## Structure
- Shared package `seq_pkg` holds:
  - state encoding localparams (`ST_IDLE`, `ST_PLAY`)
  - default `STEPS`/`LOOP_W` values shared with the audio generators and display
- One sub-module, `edge_sync`, contains the synchroniser and history flop. It has parameters `STAGES` and `RESET_VAL`, and outputs `rise` and `fall` pulses. It is instantiated three times.
- Top level holds the FSM, `loops_q`, and the step and loop counters.

## Test plan
- Defaults, `Loops`=2, start, then 32 `Step` pulses → `LoopWrap` on the 16th and 32nd edges; `Done` and `Play`↓ on the 32nd; `LoopIdx` 0→1→0.
- `Loops`=0, start, then 200 `Step` pulses → `Play` stays 1; `StepIdx`=8, `LoopIdx`=12; `Done` never pulses.
- `Loops`=3, stop after 20 steps → `Play`↓, `StepIdx`=4, `LoopIdx`=1 hold, no `Done`. A further 10 steps change nothing.
- `Loops`=3, restart (with `Loops`=1) after 20 steps → indices 0. `Done` after 16 more steps.
- Start, stop and step edges landing in the same cycle → stop wins, `Play`=0. Start and step in the same cycle → `StepIdx`=0, step ignored.
- `STEPS`=4, `LOOP_W`=3, `Loops`=7: `Done` after 28 steps. `Reset` at step 10 → all outputs 0 next cycle, IDLE. Then count latency: `Play`↑ 3 clocks after `nStart` falls.
